// File: rtl/univ_shift_reg_pkg.sv
// Shared op encodings, burst FSM states and helpers for the universal shift register.
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_SHL  = 3'd1,
        OP_SHR  = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_ASR  = 3'd5,
        OP_LOAD = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Burst direction follows the op field: left for SHL/ROL, right otherwise.
    function automatic logic is_left(input op_e op);
        return (op == OP_SHL) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/status bundle of the universal shift register; master drives ops, slave is the register.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
);
    import univ_shift_reg_pkg::*;

    logic             clr;
    logic             op_valid;
    op_e              op;
    logic [AMT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] din;
    logic             start;
    logic [AMT_W-1:0] len;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output clr, op_valid, op, amt, sin, din, start, len,
        input  q, sout, busy, done
    );

    modport slave (
        input  clr, op_valid, op, amt, sin, din, start, len,
        output q, sout, busy, done
    );

endinterface

// File: rtl/univ_shift_reg_core.sv
// Combinational barrel shifter: next register value and shifted-out bit for one op.
// Zero latency; no flow control.
module univ_shift_reg_core
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] q_i,
    input  op_e              op_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             sout_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o
);

    localparam logic [AMT_W-1:0] W_A  = AMT_W'(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [AMT_W-1:0] a;
    logic [AMT_W-1:0] r;
    logic [AMT_W-1:0] r_inv;
    logic [WIDTH-1:0] fill_lo;
    logic [WIDTH-1:0] fill_hi;
    logic [WIDTH-1:0] last_l;
    logic [WIDTH-1:0] last_r;

    assign a       = (amt_i > W_A) ? W_A : amt_i;
    // Rotates wrap the raw amount rather than saturating it.
    assign r       = amt_i % W_A;
    assign r_inv   = W_A - r;
    assign fill_lo = sin_i ? ~(ONES << a) : '0;
    assign fill_hi = sin_i ? ~(ONES >> a) : '0;
    // Shift by a-1 so the last bit to leave sits at the edge of the word.
    assign last_l  = q_i << (a - AMT_W'(1));
    assign last_r  = q_i >> (a - AMT_W'(1));

    always_comb begin
        q_o    = q_i;
        sout_o = sout_i;
        case (op_i)
            OP_SHL: if (a != '0) begin
                q_o    = (q_i << a) | fill_lo;
                sout_o = last_l[WIDTH-1];
            end
            OP_SHR: if (a != '0) begin
                q_o    = (q_i >> a) | fill_hi;
                sout_o = last_r[0];
            end
            OP_ASR: if (a != '0) begin
                q_o    = $signed(q_i) >>> a;
                sout_o = last_r[0];
            end
            OP_ROL:  q_o = (q_i << r) | (q_i >> r_inv);
            OP_ROR:  q_o = (q_i >> r) | (q_i << r_inv);
            OP_LOAD: q_o = din_i;
            default: q_o = q_i;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-cycle ops (latency 1) plus a counted 1-bit/cycle serial burst.
// No backpressure: start and op_valid are dropped while busy; clr overrides everything.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input logic              clk,
    input logic              reset,
    univ_shift_reg_if.slave  bus
);

    localparam logic [AMT_W-1:0] W_A = AMT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_left_q, dir_left_d;

    op_e              core_op;
    logic [AMT_W-1:0] core_amt;
    logic [WIDTH-1:0] core_q;
    logic             core_sout;
    logic [AMT_W-1:0] len_c;

    assign len_c = (bus.len > W_A) ? W_A : bus.len;

    // A burst step is just a 1-bit SHL/SHR through the same shifter.
    assign core_op  = (state_q == ST_RUN) ? (dir_left_q ? OP_SHL : OP_SHR) : bus.op;
    assign core_amt = (state_q == ST_RUN) ? AMT_W'(1) : bus.amt;

    univ_shift_reg_core #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_core (
        .q_i    (q_q),
        .op_i   (core_op),
        .amt_i  (core_amt),
        .sin_i  (bus.sin),
        .din_i  (bus.din),
        .sout_i (sout_q),
        .q_o    (core_q),
        .sout_o (core_sout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            sout_q     <= 1'b0;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            sout_q     <= sout_d;
            cnt_q      <= cnt_d;
            dir_left_q <= dir_left_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        sout_d     = sout_q;
        cnt_d      = cnt_q;
        dir_left_d = dir_left_q;
        if (bus.clr) begin
            state_d = ST_IDLE;
            q_d     = '0;
            sout_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        dir_left_d = is_left(bus.op);
                        if (len_c != '0) begin
                            state_d = ST_RUN;
                            cnt_d   = len_c;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (bus.op_valid) begin
                        q_d    = core_q;
                        sout_d = core_sout;
                    end
                end
                ST_RUN: begin
                    q_d    = core_q;
                    sout_d = core_sout;
                    cnt_d  = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed vectors for univ_shift_reg (WIDTH=8); expectations queued per cycle, checked by a monitor.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(8)) bus ();

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string      nm;
        bit         ck_q;
        logic [7:0] q;
        bit         ck_s;
        logic       sout;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: one queued expectation per clock edge (or async reset edge).
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.ck_q) cmp({e.nm, ".q"}, bus.q, e.q);
                if (e.ck_s) cmp({e.nm, ".sout"}, {7'd0, bus.sout}, {7'd0, e.sout});
                cmp({e.nm, ".busy"}, {7'd0, bus.busy}, {7'd0, e.busy});
                cmp({e.nm, ".done"}, {7'd0, bus.done}, {7'd0, e.done});
            end
        end
    end

    task automatic idle_in();
        bus.clr      = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = OP_HOLD;
        bus.amt      = '0;
        bus.sin      = 1'b0;
        bus.din      = '0;
        bus.start    = 1'b0;
        bus.len      = '0;
    endtask

    task automatic drv_op(input op_e o, input logic [3:0] a, input logic s, input logic [7:0] d);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.amt      = a;
        bus.sin      = s;
        bus.din      = d;
    endtask

    task automatic drv_start(input op_e o, input logic [3:0] l, input logic s);
        bus.start = 1'b1;
        bus.op    = o;
        bus.len   = l;
        bus.sin   = s;
    endtask

    // Queue the expectation for the coming edge, let it pass, then return inputs to idle.
    task automatic step(input string nm, input bit ck_q, input logic [7:0] eq,
                        input bit ck_s, input logic es, input logic eb, input logic ed);
        exp_t e;
        e.nm = nm; e.ck_q = ck_q; e.q = eq; e.ck_s = ck_s; e.sout = es; e.busy = eb; e.done = ed;
        sb.push_back(e);
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] qs [8];
        logic       so [8];
        exp_t       ea;
        qs = '{8'h62, 8'h31, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h01, 8'h00};
        so = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        idle_in();
        @(negedge clk);
        step("rst", 1, 8'h00, 1, 0, 0, 0);
        reset = 1'b0;

        // Reset mid-burst acts without a clock edge
        drv_op(OP_LOAD, 4'd0, 1'b0, 8'hA5);  step("t1_load", 1, 8'hA5, 1, 0, 0, 0);
        drv_start(OP_SHR, 4'd6, 1'b0);       step("t1_start", 1, 8'hA5, 0, 0, 1, 0);
        step("t1_run1", 1, 8'h52, 1, 1, 1, 0);
        step("t1_run2", 1, 8'h29, 1, 0, 1, 0);
        step("t1_run3", 1, 8'h14, 1, 1, 1, 0);
        ea.nm = "t1_async_rst"; ea.ck_q = 1; ea.q = 8'h00; ea.ck_s = 1; ea.sout = 0;
        ea.busy = 0; ea.done = 0;
        sb.push_back(ea);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step("t1_after_rst", 1, 8'h00, 1, 0, 0, 0);

        // Multi-bit shifts
        drv_op(OP_LOAD, 4'd0, 1'b0, 8'hB4);  step("t2_load", 1, 8'hB4, 1, 0, 0, 0);
        drv_op(OP_SHL, 4'd3, 1'b1, 8'h00);   step("t2_shl3", 1, 8'hA7, 1, 1, 0, 0);
        drv_op(OP_SHR, 4'd2, 1'b0, 8'h00);   step("t2_shr2", 1, 8'h29, 1, 1, 0, 0);

        // Rotate wrap, arithmetic shift, zero amount, amount clamp
        drv_op(OP_LOAD, 4'd0, 1'b0, 8'h81);  step("t3_load81", 1, 8'h81, 1, 1, 0, 0);
        drv_op(OP_ROL, 4'd9, 1'b0, 8'h00);   step("t3_rol9", 1, 8'h03, 1, 1, 0, 0);
        drv_op(OP_LOAD, 4'd0, 1'b0, 8'h80);  step("t3_load80", 1, 8'h80, 1, 1, 0, 0);
        drv_op(OP_ASR, 4'd3, 1'b0, 8'h00);   step("t3_asr3", 1, 8'hF0, 1, 0, 0, 0);
        drv_op(OP_ASR, 4'd0, 1'b0, 8'h00);   step("t3_asr0", 1, 8'hF0, 1, 0, 0, 0);
        drv_op(OP_SHL, 4'd0, 1'b1, 8'h00);   step("t3_shl0", 1, 8'hF0, 1, 0, 0, 0);
        drv_op(OP_ROR, 4'd4, 1'b0, 8'h00);   step("t3_ror4", 1, 8'h0F, 1, 0, 0, 0);
        drv_op(OP_NOP, 4'd5, 1'b1, 8'h55);   step("t3_op7", 1, 8'h0F, 1, 0, 0, 0);
        drv_op(OP_SHL, 4'd15, 1'b1, 8'h00);  step("t3_shl15", 1, 8'hFF, 1, 1, 0, 0);
        drv_op(OP_SHR, 4'd8, 1'b0, 8'h00);   step("t3_shr8", 1, 8'h00, 1, 1, 0, 0);
        drv_op(OP_SHR, 4'd8, 1'b1, 8'h00);   step("t3_shr8_fill", 1, 8'hFF, 1, 0, 0, 0);

        // Right burst of 8; ops and start during RUN must be ignored
        drv_op(OP_LOAD, 4'd0, 1'b0, 8'hC5);  step("t4_load", 1, 8'hC5, 1, 0, 0, 0);
        drv_start(OP_SHR, 4'd8, 1'b0);       step("t4_start", 1, 8'hC5, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) drv_op(OP_LOAD, 4'd0, 1'b0, 8'hFF);
            if (i == 4) drv_start(OP_SHL, 4'd2, 1'b1);
            bus.sin = 1'b0;
            step($sformatf("t4_run%0d", i), 1, qs[i], 1, so[i], 1, (i == 7));
        end
        step("t4_idle", 1, 8'h00, 1, 1, 0, 0);

        // Zero-length burst, start while busy
        drv_start(OP_SHR, 4'd0, 1'b0);       step("t5_len0", 1, 8'h00, 1, 1, 1, 1);
        drv_start(OP_SHR, 4'd3, 1'b0);       step("t5_start_busy", 1, 8'h00, 1, 1, 0, 0);
        step("t5_still_idle", 1, 8'h00, 1, 1, 0, 0);

        // Left burst with sin=1, then length clamp (15 -> 8)
        drv_op(OP_LOAD, 4'd0, 1'b0, 8'h81);  step("t5_load81", 1, 8'h81, 1, 1, 0, 0);
        drv_start(OP_ROL, 4'd2, 1'b1);       step("t5_lstart", 1, 8'h81, 1, 1, 1, 0);
        bus.sin = 1'b1;                      step("t5_l1", 1, 8'h03, 1, 1, 1, 0);
        bus.sin = 1'b1;                      step("t5_l2", 1, 8'h07, 1, 0, 1, 1);
        step("t5_lidle", 1, 8'h07, 1, 0, 0, 0);
        drv_start(OP_SHL, 4'd15, 1'b1);      step("t5_cstart", 1, 8'h07, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            bus.sin = 1'b1;
            step($sformatf("t5_clamp%0d", i), (i == 7), 8'hFF, (i == 7), 1'b1, 1, (i == 7));
        end
        step("t5_cidle", 1, 8'hFF, 1, 1, 0, 0);

        // Priority: clr over start, start over op_valid, clr aborts burst
        drv_start(OP_SHR, 4'd4, 1'b0); bus.clr = 1'b1;
        step("t6_clr_start", 1, 8'h00, 1, 0, 0, 0);
        step("t6_no_burst", 1, 8'h00, 1, 0, 0, 0);
        drv_op(OP_LOAD, 4'd0, 1'b0, 8'h3C);  step("t6_load", 1, 8'h3C, 1, 0, 0, 0);
        drv_op(OP_SHL, 4'd2, 1'b0, 8'h00); bus.start = 1'b1; bus.len = 4'd1;
        step("t6_both", 1, 8'h3C, 1, 0, 1, 0);
        step("t6_burst", 1, 8'h78, 1, 0, 1, 1);
        step("t6_end", 1, 8'h78, 1, 0, 0, 0);
        drv_start(OP_SHR, 4'd3, 1'b0);       step("t6_astart", 1, 8'h78, 1, 0, 1, 0);
        step("t6_arun", 1, 8'h3C, 1, 0, 1, 0);
        bus.clr = 1'b1;                      step("t6_abort", 1, 8'h00, 1, 0, 0, 0);
        step("t6_aidle", 1, 8'h00, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
